// File: rtl/gf2m8_vec_mul_gated.sv
// rtl/gf2m8_vec_mul_gated.sv - GF(2^8) scalar-by-vector multiplier with clock-gated result register

// Single-lane GF(2^8) multiplier: carry-less product, then MSB-first polynomial reduction.
module gf2m8_mul #(
  parameter logic [7:0] POLY = 8'h1D
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [14:0] prod;

  // Shift-and-xor partial products, then fold bits 14..8 back into the low byte.
  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        prod = prod ^ ({7'b0, a} << i);
      end
    end
    for (int k = 14; k >= 8; k--) begin
      if (prod[k]) begin
        prod = prod ^ ({6'b0, 1'b1, POLY} << (k - 8));
      end
    end
    p = prod[7:0];
  end

endmodule

// Scales every lane of y by x; z is combinational, z_q is a gated-clock registered copy.
module gf2m8_vec_mul_gated #(
  parameter int          LANES = 6,
  parameter logic [7:0]  POLY  = 8'h1D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [7:0]           x,
  input  logic [8*LANES-1:0]   y,
  output logic [8*LANES-1:0]   z,
  output logic [8*LANES-1:0]   z_q,
  output logic                 vld_q
);

  logic                 ge;
  logic                 ge_lat;
  logic                 gclk;
  logic [8*LANES-1:0]   z_d;
  logic                 vld_d;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gf2m8_mul #(.POLY(POLY)) u_mul (
      .a (x),
      .b (y[8*g +: 8]),
      .p (z[8*g +: 8])
    );
  end

  // Gate enable: reset must also reach the gated register so it can clear.
  always_comb begin
    ge = en | rst;
  end

  // Enable latch is transparent only while clk is low, so gclk cannot glitch in the high phase.
  always_latch begin
    if (!clk) begin
      ge_lat <= ge;
    end
  end

  assign gclk = clk & ge_lat;

  // Next-state values for the result register and the valid flag.
  always_comb begin
    z_d   = z;
    vld_d = en;
  end

  // Result register sits behind the gate: it only sees edges on enabled or reset cycles.
  always_ff @(posedge gclk) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  // Valid runs on the free clock so it drops on the first non-enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

endmodule

// File: tb/tb_gf2m8_vec_mul_gated.sv
// tb/tb_gf2m8_vec_mul_gated.sv - self-checking bench for gf2m8_vec_mul_gated

module tb_gf2m8_vec_mul_gated;

  localparam int LANES = 6;
  localparam int W     = 8 * LANES;

  logic          clk;
  logic          rst;
  logic          en;
  logic [7:0]    x;
  logic [W-1:0]  y;
  logic [W-1:0]  z;
  logic [W-1:0]  z_q;
  logic          vld_q;

  int n_tests;
  int n_fail;
  int gclk_cnt;

  typedef struct {
    logic [7:0]   x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } vec_t;

  vec_t tbl [6];

  gf2m8_vec_mul_gated #(.LANES(LANES), .POLY(8'h1D)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .x     (x),
    .y     (y),
    .z     (z),
    .z_q   (z_q),
    .vld_q (vld_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge dut.gclk) gclk_cnt <= gclk_cnt + 1;

  // Reference multiply: Russian-peasant with xtime (multiply-by-alpha) reduction.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    logic [7:0] bb;
    r  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] vec_ref(input logic [7:0] s, input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = gf_ref(s, v[8*i +: 8]);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  logic [W-1:0] exp_zq;
  logic         exp_vld;
  logic [W-1:0] prev;
  logic [7:0]   r1;
  logic [7:0]   a8;
  logic [7:0]   b8;
  int           g0;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    gclk_cnt = 0;
    rst = 1'b1;
    en  = 1'b0;
    x   = 8'h00;
    y   = '0;

    tbl[0] = '{8'h02, {8'h03, 8'hFF, 8'h00, 8'h01, 8'h8E, 8'h80}, {8'h06, 8'hE3, 8'h00, 8'h02, 8'h01, 8'h1D}};
    tbl[1] = '{8'h80, {6{8'h80}}, {6{8'h13}}};
    tbl[2] = '{8'h03, {6{8'h03}}, {6{8'h05}}};
    tbl[3] = '{8'h01, {8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h12, 8'h80}, {8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h12, 8'h80}};
    tbl[4] = '{8'h00, {8'hA5, 8'h5A, 8'h01, 8'hFF, 8'h12, 8'h80}, {6{8'h00}}};
    tbl[5] = '{8'hFF, {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02}, {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hE3}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_zq", z_q, '0);
    check("reset_vld", {47'b0, vld_q}, 48'd1 >> 1);

    // Table vectors, back-to-back enabled loads
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      x  = tbl[i].x;
      y  = tbl[i].y;
      en = 1'b1;
      #1;
      check($sformatf("tbl%0d_z", i), z, tbl[i].z);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_zq", i), z_q, tbl[i].z);
      check($sformatf("tbl%0d_vld", i), {47'b0, vld_q}, 48'd1);
    end

    // Hold: load all-02, then three idle cycles with x changing
    @(negedge clk);
    x = 8'h02; y = {6{8'h01}}; en = 1'b1;
    @(posedge clk);
    #1;
    check("hold_load", z_q, {6{8'h02}});
    @(negedge clk);
    en = 1'b0; x = 8'hFF;
    g0 = gclk_cnt;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_zq", c), z_q, {6{8'h02}});
      check($sformatf("hold%0d_vld", c), {47'b0, vld_q}, '0);
      check($sformatf("hold%0d_z", c), z, {6{8'hFF}});
    end
    check("hold_gclk_flat", 48'(gclk_cnt), 48'(g0));

    // Reset with en in the same cycle
    @(negedge clk);
    x = 8'h05; y = rand_vec(); en = 1'b1;
    @(negedge clk);
    rst = 1'b1; x = 8'h07; y = rand_vec();
    @(posedge clk);
    #1;
    check("rst_en_zq", z_q, '0);
    check("rst_en_vld", {47'b0, vld_q}, '0);
    @(negedge clk);
    rst = 1'b0; x = 8'h09; y = rand_vec();
    @(posedge clk);
    #1;
    check("post_rst_zq", z_q, vec_ref(8'h09, y));
    check("post_rst_vld", {47'b0, vld_q}, 48'd1);

    // en pulse inside the clk high phase must not create a gclk edge
    @(negedge clk);
    en = 1'b0;
    prev = z_q;
    g0 = gclk_cnt;
    x = 8'h33;
    @(posedge clk);
    #2 en = 1'b1;
    #1 en = 1'b0;
    @(negedge clk);
    #1;
    check("glitch_cnt_idle", 48'(gclk_cnt), 48'(g0));
    check("glitch_zq_idle", z_q, prev);

    // en dropping inside the high phase must not truncate the gclk pulse
    @(negedge clk);
    en = 1'b1; x = 8'h44; y = rand_vec();
    g0 = gclk_cnt;
    @(posedge clk);
    #2 en = 1'b0;
    #1;
    check("gclk_held_high", {47'b0, dut.gclk}, 48'd1);
    @(negedge clk);
    #1;
    check("glitch_cnt_en", 48'(gclk_cnt), 48'(g0 + 1));
    check("glitch_zq_en", z_q, vec_ref(8'h44, y));

    // Randomized traffic against a register scoreboard
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(posedge clk);
    exp_zq  = '0;
    exp_vld = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      x   = 8'($urandom);
      y   = rand_vec();
      en  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 15) == 0);
      #1;
      check("rand_z", z, vec_ref(x, y));
      if (rst) begin
        exp_zq = '0; exp_vld = 1'b0;
      end else if (en) begin
        exp_zq = vec_ref(x, y); exp_vld = 1'b1;
      end else begin
        exp_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      check("rand_zq", z_q, exp_zq);
      check("rand_vld", {47'b0, vld_q}, {47'b0, exp_vld});
    end

    // Exhaustive lane 0
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        x = 8'(a);
        y = {40'b0, 8'(b)};
        #1;
        check("exh_lane0", {40'b0, z[7:0]}, {40'b0, gf_ref(8'(a), 8'(b))});
      end
    end

    // Field identities
    for (int v = 0; v < 256; v++) begin
      x = 8'h00; y = {{5{8'h5C}}, 8'(v)};
      #1;
      check("zero_x", z, '0);
      x = 8'(v); y = '0;
      #1;
      check("zero_y", z, '0);
      x = 8'h01; y = {{5{8'(v)}}, 8'(v)};
      #1;
      check("one_x", z, y);
      x = 8'(v); y = {6{8'h01}};
      #1;
      check("one_y", z, {6{8'(v)}});
    end

    // Commutativity
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      x = a8; y = {40'b0, b8};
      #1;
      r1 = z[7:0];
      x = b8; y = {40'b0, a8};
      #1;
      check("commute", {40'b0, z[7:0]}, {40'b0, r1});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
